// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: entry status word and NZP bit positions.
package rob_pkg;

  localparam int ARCH_REG_W = 3;
  localparam int CC_W       = 3;

  // Bit positions inside a 3-bit condition code (N is the MSB).
  typedef enum logic [1:0] {
    CC_BIT_P = 2'd0,
    CC_BIT_Z = 2'd1,
    CC_BIT_N = 2'd2
  } nzp_bit_e;

  // Per-entry status. PC and result data live in separate arrays because their widths are parameters of the top.
  typedef struct packed {
    logic                  valid;
    logic                  ready;
    logic                  wr;
    logic                  setcc;
    logic [ARCH_REG_W-1:0] dest;
    logic [CC_W-1:0]       cc;
  } rob_entry_t;

endpackage

// File: rtl/rob_lane_alloc.sv
// Per-lane prefix-count index generator: lane k maps to base plus the number of requesting lanes below it.
module rob_lane_alloc #(
  parameter int DISPATCH_W = 4,
  parameter int IDX_W      = 6
) (
  input  logic [IDX_W-1:0]            base,
  input  logic [DISPATCH_W-1:0]       req,
  output logic [DISPATCH_W*IDX_W-1:0] idx,
  output logic [IDX_W-1:0]            next_base
);

  always_comb begin
    logic [IDX_W-1:0] acc;
    acc = base;
    idx = '0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      idx[k*IDX_W +: IDX_W] = acc;
      acc = acc + IDX_W'(req[k]);
    end
    next_base = acc;
  end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order multi-lane allocation, CDB result capture, in-order multi-lane retire and full flush.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int DISPATCH_W = 4,
  parameter int CDB_PORTS  = 4,
  parameter int COMMIT_W   = 2,
  parameter int DATA_W     = 16,
  parameter int PC_W       = 16,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic [DISPATCH_W-1:0]          disp_valid,
  input  logic [DISPATCH_W*PC_W-1:0]     disp_pc,
  input  logic [DISPATCH_W*ARCH_REG_W-1:0] disp_dest,
  input  logic [DISPATCH_W-1:0]          disp_wr,
  input  logic [DISPATCH_W-1:0]          disp_setcc,
  output logic                           disp_ready,
  output logic [DISPATCH_W*IDX_W-1:0]    disp_idx,
  input  logic [CDB_PORTS-1:0]           cdb_valid,
  input  logic [CDB_PORTS*IDX_W-1:0]     cdb_idx,
  input  logic [CDB_PORTS*DATA_W-1:0]    cdb_data,
  input  logic [CDB_PORTS*CC_W-1:0]      cdb_cc,
  output logic [COMMIT_W-1:0]            commit_valid,
  output logic [COMMIT_W-1:0]            commit_wr,
  output logic [COMMIT_W-1:0]            commit_setcc,
  output logic [COMMIT_W*ARCH_REG_W-1:0] commit_dest,
  output logic [COMMIT_W*DATA_W-1:0]     commit_data,
  output logic [COMMIT_W*CC_W-1:0]       commit_cc,
  output logic [COMMIT_W*PC_W-1:0]       commit_pc,
  output logic [IDX_W:0]                 count,
  output logic                           empty,
  output logic                           full
);

  rob_entry_t        ent      [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [IDX_W-1:0]          head, tail, head_nxt, tail_nxt;
  logic [IDX_W-1:0]          disp_step, ret_step;
  logic [IDX_W:0]            disp_n, ret_n;
  logic                      disp_fire;
  logic [COMMIT_W-1:0]       ret_mask;
  logic [COMMIT_W*IDX_W-1:0] ret_slot;
  logic [CDB_PORTS-1:0]      cdb_hit;

  assign disp_ready = (count <= (IDX_W+1)'(DEPTH - DISPATCH_W));
  assign disp_fire  = disp_ready && (|disp_valid);
  assign empty      = (count == '0);
  assign full       = (count == (IDX_W+1)'(DEPTH));

  rob_lane_alloc #(.DISPATCH_W(DISPATCH_W), .IDX_W(IDX_W)) u_disp_alloc (
    .base      (tail),
    .req       (disp_valid),
    .idx       (disp_idx),
    .next_base (tail_nxt)
  );

  // Retire is the longest run of valid+ready entries starting at head.
  always_comb begin
    logic run;
    run      = 1'b1;
    ret_mask = '0;
    for (int j = 0; j < COMMIT_W; j++) begin
      run = run && ent[head + IDX_W'(j)].valid && ent[head + IDX_W'(j)].ready;
      ret_mask[j] = run;
    end
  end

  rob_lane_alloc #(.DISPATCH_W(COMMIT_W), .IDX_W(IDX_W)) u_ret_alloc (
    .base      (head),
    .req       (ret_mask),
    .idx       (ret_slot),
    .next_base (head_nxt)
  );

  // Step sizes are below DEPTH, so modular pointer differences give exact counts.
  assign disp_step = tail_nxt - tail;
  assign ret_step  = head_nxt - head;
  assign disp_n    = disp_fire ? {1'b0, disp_step} : '0;
  assign ret_n     = {1'b0, ret_step};

  always_comb begin
    cdb_hit = '0;
    for (int p = 0; p < CDB_PORTS; p++) begin
      cdb_hit[p] = cdb_valid[p] && ent[cdb_idx[p*IDX_W +: IDX_W]].valid
                   && !ent[cdb_idx[p*IDX_W +: IDX_W]].ready;
    end
  end

  // Control state and registered commit stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      commit_valid <= '0;
      commit_wr    <= '0;
      commit_setcc <= '0;
      commit_dest  <= '0;
      commit_data  <= '0;
      commit_cc    <= '0;
      commit_pc    <= '0;
    end else if (flush) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].valid <= 1'b0;
        ent[i].ready <= 1'b0;
      end
      commit_valid <= '0;
    end else begin
      for (int j = 0; j < COMMIT_W; j++) begin
        if (ret_mask[j]) begin
          ent[ret_slot[j*IDX_W +: IDX_W]].valid <= 1'b0;
          ent[ret_slot[j*IDX_W +: IDX_W]].ready <= 1'b0;
        end
      end
      // Descending loop so the lowest-numbered port lands last and wins.
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (cdb_hit[p]) begin
          ent[cdb_idx[p*IDX_W +: IDX_W]].ready <= 1'b1;
          ent[cdb_idx[p*IDX_W +: IDX_W]].cc    <= cdb_cc[p*CC_W +: CC_W];
        end
      end
      if (disp_fire) begin
        for (int k = 0; k < DISPATCH_W; k++) begin
          if (disp_valid[k]) begin
            ent[disp_idx[k*IDX_W +: IDX_W]] <= '{valid: 1'b1, ready: 1'b0,
                                                 wr: disp_wr[k], setcc: disp_setcc[k],
                                                 dest: disp_dest[k*ARCH_REG_W +: ARCH_REG_W],
                                                 cc: '0};
          end
        end
        tail <= tail_nxt;
      end
      head         <= head_nxt;
      count        <= count + disp_n - ret_n;
      commit_valid <= ret_mask;
      for (int j = 0; j < COMMIT_W; j++) begin
        commit_wr[j]                          <= ent[ret_slot[j*IDX_W +: IDX_W]].wr;
        commit_setcc[j]                       <= ent[ret_slot[j*IDX_W +: IDX_W]].setcc;
        commit_dest[j*ARCH_REG_W +: ARCH_REG_W] <= ent[ret_slot[j*IDX_W +: IDX_W]].dest;
        commit_cc[j*CC_W +: CC_W]             <= ent[ret_slot[j*IDX_W +: IDX_W]].cc;
        commit_data[j*DATA_W +: DATA_W]       <= data_mem[ret_slot[j*IDX_W +: IDX_W]];
        commit_pc[j*PC_W +: PC_W]             <= pc_mem[ret_slot[j*IDX_W +: IDX_W]];
      end
    end
  end

  // Payload arrays carry no reset; valid bits in ent qualify their contents.
  always_ff @(posedge clk) begin
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (cdb_hit[p]) data_mem[cdb_idx[p*IDX_W +: IDX_W]] <= cdb_data[p*DATA_W +: DATA_W];
    end
    if (disp_fire) begin
      for (int k = 0; k < DISPATCH_W; k++) begin
        if (disp_valid[k]) pc_mem[disp_idx[k*IDX_W +: IDX_W]] <= disp_pc[k*PC_W +: PC_W];
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against a queue-based program-order model.
module tb_reorder_buffer;

  localparam int DEPTH  = 8;
  localparam int DW     = 4;
  localparam int CP     = 4;
  localparam int CW     = 2;
  localparam int DATA_W = 16;
  localparam int PC_W   = 16;
  localparam int IW     = 3;

  logic              clk, rst_n, flush;
  logic [DW-1:0]     disp_valid, disp_wr, disp_setcc;
  logic [DW*PC_W-1:0] disp_pc;
  logic [DW*3-1:0]   disp_dest;
  logic              disp_ready;
  logic [DW*IW-1:0]  disp_idx;
  logic [CP-1:0]     cdb_valid;
  logic [CP*IW-1:0]  cdb_idx;
  logic [CP*DATA_W-1:0] cdb_data;
  logic [CP*3-1:0]   cdb_cc;
  logic [CW-1:0]     commit_valid, commit_wr, commit_setcc;
  logic [CW*3-1:0]   commit_dest, commit_cc;
  logic [CW*DATA_W-1:0] commit_data;
  logic [CW*PC_W-1:0] commit_pc;
  logic [IW:0]       count;
  logic              empty, full;

  reorder_buffer #(
    .DEPTH(DEPTH), .DISPATCH_W(DW), .CDB_PORTS(CP), .COMMIT_W(CW),
    .DATA_W(DATA_W), .PC_W(PC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_pc(disp_pc), .disp_dest(disp_dest),
    .disp_wr(disp_wr), .disp_setcc(disp_setcc), .disp_ready(disp_ready), .disp_idx(disp_idx),
    .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_data(cdb_data), .cdb_cc(cdb_cc),
    .commit_valid(commit_valid), .commit_wr(commit_wr), .commit_setcc(commit_setcc),
    .commit_dest(commit_dest), .commit_data(commit_data), .commit_cc(commit_cc),
    .commit_pc(commit_pc), .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Program-order model: one queue element per allocated instruction.
  typedef struct {
    int         idx;
    bit         rdy;
    bit         wr;
    bit         setcc;
    logic [2:0] dest;
    logic [15:0] pc;
    logic [15:0] data;
    logic [2:0] cc;
  } ment_t;

  ment_t       mq[$];
  ment_t       ne;
  ment_t       exp_c[CW];
  logic [CW-1:0] exp_cv = '0;
  int          m_tail = 0;
  int          sz, below, nret;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      mq.delete();
      m_tail = 0;
      exp_cv = '0;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_ready", disp_ready, 1);
      chk("rst_cvalid", commit_valid, 0);
      chk("rst_cdata", commit_data, 0);
      chk("rst_cpc", commit_pc, 0);
    end else begin
      sz = mq.size();
      chk("count", count, sz);
      chk("empty", empty, (sz == 0));
      chk("full", full, (sz == DEPTH));
      chk("disp_ready", disp_ready, (sz <= DEPTH - DW));
      chk("commit_valid", commit_valid, exp_cv);
      for (int j = 0; j < CW; j++) begin
        if (exp_cv[j]) begin
          chk($sformatf("commit_data%0d", j), commit_data[j*DATA_W +: DATA_W], exp_c[j].data);
          chk($sformatf("commit_pc%0d", j), commit_pc[j*PC_W +: PC_W], exp_c[j].pc);
          chk($sformatf("commit_cc%0d", j), commit_cc[j*3 +: 3], exp_c[j].cc);
          chk($sformatf("commit_dest%0d", j), commit_dest[j*3 +: 3], exp_c[j].dest);
          chk($sformatf("commit_wr%0d", j), commit_wr[j], exp_c[j].wr);
          chk($sformatf("commit_setcc%0d", j), commit_setcc[j], exp_c[j].setcc);
        end
      end
      below = 0;
      for (int k = 0; k < DW; k++) begin
        if (disp_valid[k]) begin
          chk($sformatf("disp_idx%0d", k), disp_idx[k*IW +: IW], (m_tail + below) % DEPTH);
          below++;
        end
      end
      // Advance the model across the coming edge.
      if (flush) begin
        mq.delete();
        m_tail = 0;
        exp_cv = '0;
      end else begin
        nret = 0;
        for (int j = 0; j < CW; j++)
          if (nret == j && j < sz && mq[j].rdy) nret++;
        exp_cv = '0;
        for (int j = 0; j < nret; j++) begin
          exp_cv[j] = 1'b1;
          exp_c[j]  = mq[j];
        end
        for (int p = 0; p < CP; p++) begin
          if (cdb_valid[p]) begin
            for (int i = 0; i < mq.size(); i++) begin
              if (mq[i].idx == int'(cdb_idx[p*IW +: IW])) begin
                if (!mq[i].rdy) begin
                  ne      = mq[i];
                  ne.rdy  = 1'b1;
                  ne.data = cdb_data[p*DATA_W +: DATA_W];
                  ne.cc   = cdb_cc[p*3 +: 3];
                  mq[i]   = ne;
                end
                break;
              end
            end
          end
        end
        for (int j = 0; j < nret; j++) void'(mq.pop_front());
        if (sz <= DEPTH - DW && disp_valid != '0) begin
          for (int k = 0; k < DW; k++) begin
            if (disp_valid[k]) begin
              ne.idx   = m_tail;
              ne.rdy   = 1'b0;
              ne.wr    = disp_wr[k];
              ne.setcc = disp_setcc[k];
              ne.dest  = disp_dest[k*3 +: 3];
              ne.pc    = disp_pc[k*PC_W +: PC_W];
              ne.data  = '0;
              ne.cc    = '0;
              mq.push_back(ne);
              m_tail = (m_tail + 1) % DEPTH;
            end
          end
        end
      end
    end
  end

  task automatic idle();
    flush = 0; disp_valid = '0; disp_pc = '0; disp_dest = '0; disp_wr = '0; disp_setcc = '0;
    cdb_valid = '0; cdb_idx = '0; cdb_data = '0; cdb_cc = '0;
  endtask

  task automatic set_lane(input int k, input logic [15:0] pc, input logic [2:0] dest);
    disp_valid[k] = 1'b1;
    disp_pc[k*PC_W +: PC_W] = pc;
    disp_dest[k*3 +: 3] = dest;
    disp_wr[k] = 1'b1;
    disp_setcc[k] = k[0];
  endtask

  task automatic set_cdb(input int p, input logic [IW-1:0] idx, input logic [15:0] d, input logic [2:0] cc);
    cdb_valid[p] = 1'b1;
    cdb_idx[p*IW +: IW] = idx;
    cdb_data[p*DATA_W +: DATA_W] = d;
    cdb_cc[p*3 +: 3] = cc;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk); idle();
    for (int k = 0; k < DW; k++) set_lane(k, 16'(2 * k), 3'(k + 1));
    #3 chk("t1_idx", disp_idx, 12'h688);
    chk("t1_ready", disp_ready, 1);
    @(negedge clk); idle(); set_cdb(0, 3'd1, 16'h00AA, 3'b001);
    #3 chk("t1_count", count, 4);
    @(negedge clk); idle();
    #3 chk("t1_noret", commit_valid, 0);
    @(negedge clk); idle(); set_cdb(0, 3'd0, 16'h0011, 3'b001);
    @(negedge clk); idle();
    #3 chk("t2_wait", commit_valid, 0);
    @(negedge clk); idle();
    set_lane(1, 16'h0008, 3'd5);
    set_lane(3, 16'h000A, 3'd6);
    #3 chk("t2_cvalid", commit_valid, 2'b11);
    chk("t2_cdata", commit_data, 32'h00AA_0011);
    chk("t2_cpc", commit_pc, 32'h0002_0000);
    chk("t2_count", count, 2);
    chk("t3_idx1", disp_idx[5:3], 4);
    chk("t3_idx3", disp_idx[11:9], 5);

    @(negedge clk); idle();
    for (int k = 0; k < DW; k++) set_lane(k, 16'(16'h0010 + 2 * k), 3'(k));
    #3 chk("t3_count", count, 4);
    chk("t4_wrap_idx", disp_idx, 12'h23E);
    @(negedge clk); idle();
    for (int k = 0; k < DW; k++) set_lane(k, 16'h0F00, 3'd7);
    #3 chk("t4_full", full, 1);
    chk("t4_ready", disp_ready, 0);
    chk("t4_count", count, 8);
    @(negedge clk); idle();
    set_cdb(0, 3'd3, 16'h1111, 3'b100);
    set_cdb(1, 3'd3, 16'h2222, 3'b010);
    set_cdb(2, 3'd2, 16'h0022, 3'b001);
    #3 chk("t4_ignored", count, 8);
    @(negedge clk); idle(); set_cdb(0, 3'd3, 16'h3333, 3'b010);
    @(negedge clk); idle();
    #3 chk("t5_cvalid", commit_valid, 2'b11);
    chk("t5_cdata", commit_data, 32'h1111_0022);
    chk("t5_ccc", commit_cc, 6'b100_001);
    chk("t5_count", count, 6);

    @(negedge clk); idle(); flush = 1'b1;
    for (int k = 0; k < DW; k++) set_lane(k, 16'h0200, 3'd1);
    set_cdb(0, 3'd4, 16'h4444, 3'b001);
    @(negedge clk); idle();
    #3 chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_cvalid", commit_valid, 0);
    @(negedge clk); idle(); set_lane(2, 16'h0300, 3'd2);
    #3 chk("t6_idx", disp_idx[8:6], 0);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      idle();
      if (c == 2000) begin
        rst_n = 1'b0;
        #1 chk("mid_rst_count", count, 0);
        chk("mid_rst_cvalid", commit_valid, 0);
      end
      if (c == 2003) rst_n = 1'b1;
      flush = ($urandom_range(0, 63) == 0);
      for (int k = 0; k < DW; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          set_lane(k, 16'($urandom), 3'($urandom));
          disp_wr[k] = 1'($urandom);
        end
      end
      for (int p = 0; p < CP; p++) begin
        if ($urandom_range(0, 1) == 1)
          set_cdb(p, 3'($urandom), 16'($urandom), 3'($urandom));
      end
    end

    @(negedge clk); idle();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
